stereo_voice_mixer: RTL and testbench

Frame-synchronous stereo mixer that sits directly upstream of the I2S transmitter and drives its wave_in_l/wave_in_r inputs. Once per audio frame it requests up to NUM_VOICES mono voice samples over a valid/ready stream and pans each one into left/right accumulators. It saturates the sums to BITWIDTH and presents them as double-buffered, frame-stable outputs. Runs entirely in the audio clock domain produced by the I2S block.

---
 rtl/stereo_voice_mixer.sv | 224 ++++++++++++++++++++++
 tb/tb_stereo_voice_mixer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : stereo_voice_mixer
// Summary  : Frame-synchronous stereo mixer feeding the I2S transmitter.
//            Each audio frame it pulls up to NUM_VOICES mono voices over a
//            valid/ready stream, pans them into wide left/right accumulators,
//            saturates the sums to BITWIDTH and presents them double-buffered
//            so the outputs only change on frame boundaries.
// Options  : define MIXER_CLIP_CNT_EN to add a saturating clip-frame counter
//            (clip_count output, clip_count_clr input).
// Revision : 1.0 - initial release
// ============================================================================
module stereo_voice_mixer #(
    parameter int BITWIDTH   = 24,
    parameter int NUM_VOICES = 16,
    parameter int PAN_WIDTH  = 8
) (
    input  logic                 aud_clk,
    input  logic                 aud_rst,
    input  logic                 i2s_lrck,
    input  logic [BITWIDTH-1:0]  voice_data,
    input  logic [PAN_WIDTH-1:0] voice_pan,
    input  logic                 voice_last,
    input  logic                 voice_valid,
    output logic                 voice_ready,
    output logic                 frame_req,
    output logic [BITWIDTH-1:0]  wave_out_l,
    output logic [BITWIDTH-1:0]  wave_out_r,
    output logic                 clip_l,
    output logic                 clip_r,
    output logic                 underrun
`ifdef MIXER_CLIP_CNT_EN
    ,
    input  logic                 clip_count_clr,
    output logic [15:0]          clip_count
`endif
);

    // Product of a signed sample and an unsigned (zero-extended) gain.
    localparam int c_PROD_W = BITWIDTH + PAN_WIDTH + 1;
    // Room for NUM_VOICES full-scale products without wrapping.
    localparam int c_ACC_W  = BITWIDTH + PAN_WIDTH + $clog2(NUM_VOICES) + 1;
    localparam int c_CNT_W  = $clog2(NUM_VOICES) + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NUM_VOICES - 1);

    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX =
        {{(c_ACC_W - BITWIDTH + 1){1'b0}}, {(BITWIDTH - 1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN =
        {{(c_ACC_W - BITWIDTH + 1){1'b1}}, {(BITWIDTH - 1){1'b0}}};

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_SAT   = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic                       r_lrck_q;
    logic                       w_fe;
    logic                       w_accept;

    logic [PAN_WIDTH-1:0]       w_gain_l;
    logic [c_PROD_W-1:0]        w_data_ext;
    logic [c_PROD_W-1:0]        w_gain_l_ext;
    logic [c_PROD_W-1:0]        w_gain_r_ext;
    logic [c_PROD_W-1:0]        w_prod_l;
    logic [c_PROD_W-1:0]        w_prod_r;
    logic signed [c_ACC_W-1:0]  w_term_l;
    logic signed [c_ACC_W-1:0]  w_term_r;

    logic signed [c_ACC_W-1:0]  r_acc_l;
    logic signed [c_ACC_W-1:0]  r_acc_r;
    logic [c_CNT_W-1:0]         r_cnt;

    logic [BITWIDTH:0]          w_sat_l;
    logic [BITWIDTH:0]          w_sat_r;

    logic [BITWIDTH-1:0]        r_stg_l;
    logic [BITWIDTH-1:0]        r_stg_r;
    logic                       r_stg_clip_l;
    logic                       r_stg_clip_r;

    logic [BITWIDTH-1:0]        r_wave_l;
    logic [BITWIDTH-1:0]        r_wave_r;
    logic                       r_clip_l;
    logic                       r_clip_r;
    logic                       r_frame_req;
    logic                       r_underrun;

    // Scale down by the pan range and clamp; MSB of the result is the clip flag.
    function automatic logic [BITWIDTH:0] f_saturate(input logic signed [c_ACC_W-1:0] acc);
        logic signed [c_ACC_W-1:0] v;
        v = acc >>> PAN_WIDTH;
        if (v > c_SAT_MAX) begin
            f_saturate = {1'b1, c_SAT_MAX[BITWIDTH-1:0]};
        end else if (v < c_SAT_MIN) begin
            f_saturate = {1'b1, c_SAT_MIN[BITWIDTH-1:0]};
        end else begin
            f_saturate = {1'b0, v[BITWIDTH-1:0]};
        end
    endfunction

    assign w_fe        = i2s_lrck & ~r_lrck_q;
    // A frame edge wins over a beat offered in the same cycle.
    assign w_accept    = (r_state == c_ACCUM) & voice_valid & ~w_fe;
    assign voice_ready = (r_state == c_ACCUM);

    // Left gain is the complement of pan within the pan range.
    assign w_gain_l     = ~voice_pan;
    assign w_data_ext   = {{(PAN_WIDTH + 1){voice_data[BITWIDTH-1]}}, voice_data};
    assign w_gain_l_ext = {{(BITWIDTH + 1){1'b0}}, w_gain_l};
    assign w_gain_r_ext = {{(BITWIDTH + 1){1'b0}}, voice_pan};
    // Two's-complement low bits are exact for a product that fits c_PROD_W.
    assign w_prod_l     = w_data_ext * w_gain_l_ext;
    assign w_prod_r     = w_data_ext * w_gain_r_ext;
    assign w_term_l     = {{(c_ACC_W - c_PROD_W){w_prod_l[c_PROD_W-1]}}, w_prod_l};
    assign w_term_r     = {{(c_ACC_W - c_PROD_W){w_prod_r[c_PROD_W-1]}}, w_prod_r};

    assign w_sat_l = f_saturate(r_acc_l);
    assign w_sat_r = f_saturate(r_acc_r);

    // State register.
    always_ff @(posedge aud_clk) begin
        if (aud_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a frame edge restarts accumulation from any state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  w_state_nxt = c_IDLE;
            c_ACCUM: begin
                if (w_accept && (voice_last || (r_cnt == c_CNT_LAST))) begin
                    w_state_nxt = c_SAT;
                end
            end
            c_SAT:   w_state_nxt = c_HOLD;
            c_HOLD:  w_state_nxt = c_HOLD;
            default: w_state_nxt = c_IDLE;
        endcase
        if (w_fe) begin
            w_state_nxt = c_ACCUM;
        end
    end

    // Frame-edge detect, accumulation, staging and double-buffered outputs.
    always_ff @(posedge aud_clk) begin
        if (aud_rst) begin
            r_lrck_q     <= 1'b0;
            r_acc_l      <= '0;
            r_acc_r      <= '0;
            r_cnt        <= '0;
            r_stg_l      <= '0;
            r_stg_r      <= '0;
            r_stg_clip_l <= 1'b0;
            r_stg_clip_r <= 1'b0;
            r_wave_l     <= '0;
            r_wave_r     <= '0;
            r_clip_l     <= 1'b0;
            r_clip_r     <= 1'b0;
            r_frame_req  <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_lrck_q    <= i2s_lrck;
            r_frame_req <= w_fe;
            if (w_fe) begin
                r_wave_l <= r_stg_l;
                r_wave_r <= r_stg_r;
                r_clip_l <= r_stg_clip_l;
                r_clip_r <= r_stg_clip_r;
                r_acc_l  <= '0;
                r_acc_r  <= '0;
                r_cnt    <= '0;
                // Unfinished frame: drop partial sums, staging repeats.
                if ((r_state == c_ACCUM) || (r_state == c_SAT)) begin
                    r_underrun <= 1'b1;
                end
            end else begin
                if (w_accept) begin
                    r_acc_l <= r_acc_l + w_term_l;
                    r_acc_r <= r_acc_r + w_term_r;
                    r_cnt   <= r_cnt + 1'b1;
                end
                if (r_state == c_SAT) begin
                    r_stg_l      <= w_sat_l[BITWIDTH-1:0];
                    r_stg_r      <= w_sat_r[BITWIDTH-1:0];
                    r_stg_clip_l <= w_sat_l[BITWIDTH];
                    r_stg_clip_r <= w_sat_r[BITWIDTH];
                end
            end
        end
    end

    assign wave_out_l = r_wave_l;
    assign wave_out_r = r_wave_r;
    assign clip_l     = r_clip_l;
    assign clip_r     = r_clip_r;
    assign frame_req  = r_frame_req;
    assign underrun   = r_underrun;

`ifdef MIXER_CLIP_CNT_EN
    logic [15:0] r_clip_cnt;

    // Count frames presented with clipping; clear has priority, count saturates.
    always_ff @(posedge aud_clk) begin
        if (aud_rst) begin
            r_clip_cnt <= '0;
        end else if (clip_count_clr) begin
            r_clip_cnt <= '0;
        end else if (w_fe && (r_stg_clip_l || r_stg_clip_r) && (r_clip_cnt != 16'hFFFF)) begin
            r_clip_cnt <= r_clip_cnt + 16'd1;
        end
    end

    assign clip_count = r_clip_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stereo_voice_mixer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_stereo_voice_mixer
// Summary  : Self-checking bench for stereo_voice_mixer. Expected frame
//            outputs are queued at each frame boundary and compared when the
//            DUT pulses frame_req.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stereo_voice_mixer;

    localparam int NV = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        lrck;
    logic [23:0] vdata;
    logic [7:0]  vpan;
    logic        vlast;
    logic        vvalid;
    logic        voice_ready;
    logic        frame_req;
    logic [23:0] wave_out_l;
    logic [23:0] wave_out_r;
    logic        clip_l;
    logic        clip_r;
    logic        underrun;
`ifdef MIXER_CLIP_CNT_EN
    logic        clip_count_clr = 1'b0;
    logic [15:0] clip_count;
`endif

    stereo_voice_mixer dut (
        .aud_clk     (clk),
        .aud_rst     (rst),
        .i2s_lrck    (lrck),
        .voice_data  (vdata),
        .voice_pan   (vpan),
        .voice_last  (vlast),
        .voice_valid (vvalid),
        .voice_ready (voice_ready),
        .frame_req   (frame_req),
        .wave_out_l  (wave_out_l),
        .wave_out_r  (wave_out_r),
        .clip_l      (clip_l),
        .clip_r      (clip_r),
        .underrun    (underrun)
`ifdef MIXER_CLIP_CNT_EN
        ,
        .clip_count_clr (clip_count_clr),
        .clip_count     (clip_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        bit          cl;
        bit          cr;
        bit          ur;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: what the mixer should be holding, at frame granularity.
    longint m_stg_l, m_stg_r, m_sum_l, m_sum_r;
    bit     m_cl, m_cr, m_ur, m_open;

    logic [23:0] fd[NV];
    logic [7:0]  fp[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat24(input longint v, output bit c);
        c = 1'b0;
        if (v > 64'sd8388607) begin
            c = 1'b1;
            return 64'sd8388607;
        end
        if (v < -64'sd8388608) begin
            c = 1'b1;
            return -64'sd8388608;
        end
        return v;
    endfunction

    // Monitor: every frame_req pulse presents a new frame on the outputs.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && frame_req === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_req_unexpected actual=1 expected=0 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("wave_out_l", {8'h0, wave_out_l}, {8'h0, e.l});
                chk("wave_out_r", {8'h0, wave_out_r}, {8'h0, e.r});
                chk("clip_l", {31'h0, clip_l}, {31'h0, e.cl});
                chk("clip_r", {31'h0, clip_r}, {31'h0, e.cr});
                chk("underrun", {31'h0, underrun}, {31'h0, e.ur});
                chk("ready_after_frame_req", {31'h0, voice_ready}, 32'h1);
            end
        end
    end

    task automatic model_reset();
        m_stg_l = 0; m_stg_r = 0; m_cl = 0; m_cr = 0; m_ur = 0; m_open = 0;
        m_sum_l = 0; m_sum_r = 0;
    endtask

    // Frame boundary: optionally offer a beat in the same cycle (must be dropped).
    task automatic boundary(input bit collide);
        exp_t e;
        @(negedge clk);
        lrck = 1'b1;
        if (collide) begin
            vvalid = 1'b1;
            vdata  = 24'h7FFFFF;
            vpan   = 8'h00;
            vlast  = 1'b1;
        end
        if (m_open) m_ur = 1'b1;
        e.l = m_stg_l[23:0]; e.r = m_stg_r[23:0];
        e.cl = m_cl; e.cr = m_cr; e.ur = m_ur;
        exp_q.push_back(e);
        m_open = 1'b1; m_sum_l = 0; m_sum_r = 0;
        @(negedge clk);
        lrck = 1'b0; vvalid = 1'b0; vlast = 1'b0;
    endtask

    task automatic send_beat(input logic [23:0] d, input logic [7:0] p, input bit last);
        bit     got;
        longint dv;
        got = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        vdata = d; vpan = p; vlast = last; vvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (voice_ready === 1'b1) begin
                got = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        vvalid = 1'b0; vlast = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout actual=no_ready expected=ready at %0t", $time);
        end else begin
            dv = $signed(d);
            m_sum_l += dv * (255 - int'(p));
            m_sum_r += dv * int'(p);
        end
    endtask

    // One frame of n beats from fd/fp; completes if last is sent or n reaches NV.
    task automatic frame(input int n, input bit with_last, input bit finish_it);
        boundary(1'b0);
        for (int i = 0; i < n; i++) begin
            send_beat(fd[i], fp[i], with_last && (i == n - 1));
        end
        if (finish_it && (with_last || n == NV)) begin
            chk("ready_drop_after_final", {31'h0, voice_ready}, 32'h0);
            m_stg_l = sat24(m_sum_l >>> 8, m_cl);
            m_stg_r = sat24(m_sum_r >>> 8, m_cr);
            m_open  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_wave_l"},   {8'h0, wave_out_l}, 32'h0);
        chk({tag, "_wave_r"},   {8'h0, wave_out_r}, 32'h0);
        chk({tag, "_clip"},     {30'h0, clip_l, clip_r}, 32'h0);
        chk({tag, "_underrun"}, {31'h0, underrun}, 32'h0);
        chk({tag, "_ready"},    {31'h0, voice_ready}, 32'h0);
        chk({tag, "_frame_req"},{31'h0, frame_req}, 32'h0);
    endtask

    task automatic random_fill(output int n, output bit with_last);
        n = $urandom_range(1, NV);
        with_last = (n < NV) ? 1'b1 : 1'($urandom_range(0, 1));
        for (int i = 0; i < NV; i++) begin
            fd[i] = 24'($urandom());
            fp[i] = 8'($urandom());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit wl;
        rst = 1'b1; lrck = 1'b0; vvalid = 1'b0; vlast = 1'b0; vdata = '0; vpan = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'h0, voice_ready}, 32'h0);

        // One voice, pan full left.
        fd[0] = 24'h100000; fp[0] = 8'd0;
        frame(1, 1'b1, 1'b1);
        // Two voices with mixed pan.
        fd[0] = 24'h100000; fp[0] = 8'd128;
        fd[1] = 24'hF00000; fp[1] = 8'd255;
        frame(2, 1'b1, 1'b1);
        // Full positive scale, count-terminated.
        for (int i = 0; i < NV; i++) begin fd[i] = 24'h7FFFFF; fp[i] = 8'd0; end
        frame(NV, 1'b0, 1'b1);
        // Full negative scale.
        for (int i = 0; i < NV; i++) begin fd[i] = 24'h800000; fp[i] = 8'd0; end
        frame(NV, 1'b0, 1'b1);
        // Partial frame followed by a boundary with a colliding beat.
        random_fill(n, wl);
        frame(3, 1'b0, 1'b0);
        boundary(1'b1);
        for (int i = 0; i < 5; i++) send_beat(24'($urandom()), 8'($urandom()), i == 4);
        chk("ready_drop_after_last", {31'h0, voice_ready}, 32'h0);
        m_stg_l = sat24(m_sum_l >>> 8, m_cl);
        m_stg_r = sat24(m_sum_r >>> 8, m_cr);
        m_open  = 1'b0;
        @(negedge clk);
        // Frame with no beats at all.
        boundary(1'b0);
        repeat (3) @(negedge clk);

        for (int f = 0; f < 20; f++) begin
            random_fill(n, wl);
            frame(n, wl, 1'b1);
        end

        // Reset in the middle of accumulation.
        random_fill(n, wl);
        frame(2, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("mid_reset");
        rst = 1'b0;
        model_reset();
        vvalid = 1'b1; vdata = 24'h7FFFFF; vpan = 8'd0; vlast = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_ready", {31'h0, voice_ready}, 32'h0);
        end
        vvalid = 1'b0; vlast = 1'b0;
        for (int f = 0; f < 2; f++) begin
            random_fill(n, wl);
            frame(n, wl, 1'b1);
        end
        boundary(1'b0);
        repeat (4) @(negedge clk);

        chk("pending_expectations", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
